// File: rtl/neuron_pkg.sv
// neuron_pkg: shared types and constants for the neuron MAC datapath.
// Holds the FSM state enum, data widths and output saturation limits.
package neuron_pkg;

    localparam int DATA_W  = 7;
    localparam int OUT_W   = 14;
    localparam int PROD_W  = 2 * DATA_W;
    localparam int SAT_MAX = 8191;
    localparam int SAT_MIN = -8192;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FINAL = 2'd2
    } state_t;

    // Accumulator width large enough that N products never overflow.
    function automatic int acc_width(input int n);
        return 15 + $clog2(n);
    endfunction

endpackage

// File: rtl/neuron_mac_if.sv
// neuron_mac_if: start/bias, x/w valid-ready stream and result outputs.
// master drives stimulus, slave is the neuron_mac side.
interface neuron_mac_if;
    import neuron_pkg::*;

    logic                     start;
    logic signed [OUT_W-1:0]  bias;
    logic signed [DATA_W-1:0] x;
    logic signed [DATA_W-1:0] w;
    logic                     in_valid;
    logic                     in_ready;
    logic                     busy;
    logic signed [OUT_W-1:0]  out;
    logic                     out_en;

    modport master (
        output start, bias, x, w, in_valid,
        input  in_ready, busy, out, out_en
    );

    modport slave (
        input  start, bias, x, w, in_valid,
        output in_ready, busy, out, out_en
    );

endinterface

// File: rtl/nn_sat14.sv
// nn_sat14: clamps a wide signed sum into 14-bit signed range.
// NEURON_RELU_EN adds a ReLU stage after the clamp.
module nn_sat14
    import neuron_pkg::*;
#(
    parameter int IN_W = 18
) (
    input  logic signed [IN_W-1:0]  s,
    output logic signed [OUT_W-1:0] y
);

    localparam logic signed [IN_W-1:0] HI = IN_W'(SAT_MAX);
    localparam logic signed [IN_W-1:0] LO = IN_W'(SAT_MIN);

    logic signed [OUT_W-1:0] clamped;

    // Clamp to [SAT_MIN, SAT_MAX]; in range the low bits are exact.
    always_comb begin
        clamped = s[OUT_W-1:0];
        if (s > HI)
            clamped = OUT_W'(SAT_MAX);
        else if (s < LO)
            clamped = OUT_W'(SAT_MIN);
    end

    // Optional ReLU on the clamped value.
    always_comb begin
        y = clamped;
`ifdef NEURON_RELU_EN
        if (clamped[OUT_W-1])
            y = '0;
`endif
    end

endmodule

// File: rtl/neuron_mac.sv
// neuron_mac: sequential multiply-accumulate neuron with bias and 14-bit
// saturated output pulse. Optional ReLU via NEURON_RELU_EN.
module neuron_mac
    import neuron_pkg::*;
#(
    parameter int N_INPUTS = 4
) (
    input logic        Clk,
    input logic        Rst,
    neuron_mac_if.slave bus
);

    localparam int ACC_W = acc_width(N_INPUTS);
    localparam int SUM_W = ACC_W + 1;
    localparam int CNT_W = $clog2(N_INPUTS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_INPUTS - 1);

    state_t                  state;
    logic signed [ACC_W-1:0] acc;
    logic [CNT_W-1:0]        cnt;
    logic signed [OUT_W-1:0] bias_q;
    logic signed [OUT_W-1:0] out_q;
    logic                    out_en_q;

    logic signed [PROD_W-1:0] prod;
    logic signed [SUM_W-1:0]  sum;
    logic signed [OUT_W-1:0]  sat;

    assign prod = bus.x * bus.w;
    assign sum  = SUM_W'(acc) + SUM_W'(bias_q);

    nn_sat14 #(
        .IN_W (SUM_W)
    ) u_sat (
        .s (sum),
        .y (sat)
    );

    // Evaluation FSM: latch bias, accumulate N pairs, emit saturated result.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            bias_q   <= '0;
            out_q    <= '0;
            out_en_q <= 1'b0;
        end else begin
            out_en_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        acc    <= '0;
                        cnt    <= '0;
                        bias_q <= bus.bias;
                        state  <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (bus.in_valid) begin
                        acc <= acc + ACC_W'(prod);
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == LAST)
                            state <= FINAL;
                    end
                end
                FINAL: begin
                    out_q    <= sat;
                    out_en_q <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready = (state == ACCUM);
    assign bus.busy     = (state != IDLE);
    assign bus.out      = out_q;
    assign bus.out_en   = out_en_q;

endmodule

// File: doc/neuron_mac.md
# neuron_mac

Sequential multiply-accumulate neuron for the Simple NN datapath. It consumes N_INPUTS signed 7-bit input/weight pairs over a valid/ready handshake and adds a bias. It saturates the result to 14-bit signed and emits it with a one-cycle `out_en` pulse. That pulse drives the `a`/`enable` pins of the downstream 14-bit layer register directly.

## Interface
- `N_INPUTS`, default 4: number of input/weight pairs per neuron evaluation (≥2).
- `Clk`  in  1  clock; all logic on rising edge.
- `Rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  begin an evaluation; honoured only in IDLE.
- `bias`  in  14  signed bias; sampled on the accepted `start` edge.
- `x`  in  7  signed input activation.
- `w`  in  7  signed weight.
- `in_valid`  in  1  `x`/`w` valid.
- `in_ready`  out  1  block accepts a pair; transfer when `in_valid & in_ready`.
- `busy`  out  1  high in any state other than IDLE.
- `out`  out  14  signed neuron result; holds until the next result.
- `out_en`  out  1  one-cycle pulse; `out` is valid in the same cycle.

## Operation
- FSM states: IDLE, ACCUM, FINAL.
- IDLE: `in_ready`=0. On `start` the block clears `acc` and `cnt` to 0, latches `bias`, and moves to ACCUM.
- ACCUM: `in_ready`=1. On each handshake, `acc += x*w` and `cnt++`.
  - The handshake with `cnt == N_INPUTS-1` moves the FSM to FINAL.
  - Cycles without `in_valid` change nothing.
- FINAL: `in_ready`=0. The block computes `s = acc + sext(bias)`, clamps `s` to [-8192, 8191], and registers the clamped value into `out`. It sets `out_en`=1 for the next cycle and returns to IDLE.
- Width rules:
  - The product is 14-bit signed.
  - The accumulator is ACC_W = 15 + clog2(N_INPUTS) bits signed, so it never overflows internally.
  - The bias sum is performed at ACC_W+1 bits.
  - Saturation is applied only once, at output.
- `start` outside IDLE is ignored. `start` in the IDLE cycle where `out_en` is high is accepted.
- Reset values: `out`=0, `out_en`=0, `in_ready`=0, `busy`=0, state=IDLE, `acc`=0, `cnt`=0.
- Rst mid-operation aborts the evaluation. `out` returns to 0 and no `out_en` pulse is produced for the aborted evaluation.

## Timing
- The `start` edge at cycle t makes `in_ready`=1 from cycle t+1.
- The last handshake at edge k puts the FSM in FINAL during cycle k+1. `out` and `out_en` are valid in cycle k+2; `out_en` falls in k+3.
- The minimum evaluation is N_INPUTS+3 cycles from `start` to `out_en`.
- `out_en` is exactly one cycle wide and never asserted during reset.

## Configuration
- `NEURON_RELU_EN` defined: a ReLU is applied after saturation, so a negative clamped result gives `out`=0. The output range is [0, 8191].
- `NEURON_RELU_EN` undefined: `out` is the raw saturated signed sum.
- No other behaviour depends on the macro.

## Structure
- Package `neuron_pkg` holds:
  - the state enum (IDLE/ACCUM/FINAL);
  - DATA_W=7 and OUT_W=14;
  - the saturation limits SAT_MAX=8191 and SAT_MIN=-8192.
- One sub-module: `nn_sat14`, a combinational clamp from ACC_W+1 bits to 14 bits with the optional ReLU stage. It is instantiated once in FINAL-path logic.

## Test plan
- x={1,2,3,4}, w={1,1,1,1}, bias=0, continuous valid -> `out`=10, a single `out_en` pulse 2 cycles after the last handshake, `busy` low afterwards.
- x=63 ×4, w=63 ×4, bias=8191 -> sum 24067 -> `out`=8191 (positive saturation).
- x=-64 ×4, w=63 ×4, bias=-100 -> `out`=-8192 without `NEURON_RELU_EN`, 0 with it.
- x={5,-3,2,7}, w={2,4,-6,1}, bias=20 with `in_valid` low for 3 cycles between pairs 2 and 3, plus a `start` pulse during ACCUM -> `out`=13 (10-12-12+7+20), with the stray `start` ignored.
- Rst after 2 handshakes -> `out`=0, `in_ready`=0, IDLE, no `out_en`. A new evaluation x={1,1,1,1}, w={2,2,2,2}, bias=1 -> `out`=9.
- `start` asserted in the `out_en` cycle of a previous result -> second evaluation accepted with no lost cycle. Both results are correct.
